wptr_full_ctrl: RTL and testbench

Write-domain pointer and status block for the dual-clock asynchronous FIFO, the counterpart of the read-pointer/empty logic. It owns the binary write counter and the memory write address, and it publishes a Gray-coded write pointer for synchronisation into the read domain. From the read pointer synchronised into wclk it derives registered full, almost-full, fill-level and sticky overflow status. All logic runs in the wclk domain.

---
 rtl/wptr_full_ctrl_if.sv | 27 ++
 rtl/wptr_full_ctrl.sv | 62 ++++++
 tb/tb_wptr_full_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/wptr_full_ctrl_if.sv
// Write-side bundle of the async FIFO pointer block: request/clear in,
// synchronised read pointer in, address/pointer/status out.
interface wptr_full_ctrl_if #(
  parameter int ADDRSIZE = 4
);
  // winc is a request and wfull is the back-pressure: a write is taken on a
  // wclk edge only when winc=1 and wfull=0. A request while full is dropped.
  logic                winc;
  logic                wovf_clr;
  logic [ADDRSIZE:0]   rptr_q2;
  logic [ADDRSIZE-1:0] write_addr;
  logic [ADDRSIZE:0]   write_ptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  modport master (
    output winc, wovf_clr, rptr_q2,
    input  write_addr, write_ptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wovf_clr, rptr_q2,
    output write_addr, write_ptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full/almost-full/level/overflow status for the
// dual-clock FIFO; everything here is clocked by wclk.
module wptr_full_ctrl #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic          wclk,
  input  logic          wrst_n,
  wptr_full_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] AFULL_THRESH = (ADDRSIZE+1)'(DEPTH - AFULL_MARGIN);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next;
  logic [ADDRSIZE:0] full_ptr;
  logic              wen;

  assign wen       = bus.winc & ~bus.wfull;
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin_s[i] = ^(bus.rptr_q2 >> i);
    end
  end

  assign level_next = wbinnext - rbin_s;

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign full_ptr = {~bus.rptr_q2[ADDRSIZE:ADDRSIZE-1], bus.rptr_q2[ADDRSIZE-2:0]};

  assign bus.write_addr = wbin[ADDRSIZE-1:0];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin             <= '0;
      bus.write_ptr    <= '0;
      bus.wfull        <= 1'b0;
      bus.walmost_full <= 1'b0;
      bus.wlevel       <= '0;
      bus.woverflow    <= 1'b0;
    end else begin
      wbin             <= wbinnext;
      bus.write_ptr    <= wgraynext;
      bus.wfull        <= (wgraynext == full_ptr);
      bus.walmost_full <= (level_next >= AFULL_THRESH);
      bus.wlevel       <= level_next;
      if (bus.winc && bus.wfull) begin
        bus.woverflow <= 1'b1;
      end else if (bus.wovf_clr) begin
        bus.woverflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl: drivers queue expected output tuples,
// a monitor pops and compares them at the falling edge.
module tb_wptr_full_ctrl;
  localparam int W = 17;

  logic wclk;
  logic wrst_n;
  event sample_ev;

  wptr_full_ctrl_if #(.ADDRSIZE(4)) bus ();

  wptr_full_ctrl #(.ADDRSIZE(4), .AFULL_MARGIN(2)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  // clock / reset
  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp;
  int           n_err;
  logic [4:0]   prev_ptr;
  logic         prev_ok;

  // {write_ptr, write_addr, wfull, walmost_full, wlevel, woverflow}
  function automatic logic [W-1:0] pk(input logic [4:0] ptr, input logic [3:0] addr,
                                      input logic full, input logic afull,
                                      input logic [4:0] lvl, input logic ovf);
    return {ptr, addr, full, afull, lvl, ovf};
  endfunction

  function automatic logic [4:0] g(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  localparam logic [W-1:0] ZERO = '0;

  // scoreboard monitor
  always @(negedge wclk or sample_ev) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        nm;
    a = {bus.write_ptr, bus.write_addr, bus.wfull, bus.walmost_full, bus.wlevel, bus.woverflow};
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got ptr=%b addr=%0d full=%b afull=%b lvl=%0d ovf=%b, want ptr=%b addr=%0d full=%b afull=%b lvl=%0d ovf=%b",
                 nm, a[16:12], a[11:8], a[7], a[6], a[5:1], a[0],
                 e[16:12], e[11:8], e[7], e[6], e[5:1], e[0]);
      end
    end
    if (wrst_n && prev_ok) begin
      n_cmp++;
      if ($countones(bus.write_ptr ^ prev_ptr) > 1) begin
        n_err++;
        $display("FAIL gray_step: got %b after %b, want at most one bit change", bus.write_ptr, prev_ptr);
      end
    end
    prev_ptr = bus.write_ptr;
    prev_ok  = wrst_n;
  end

  // driver tasks
  task automatic step(input logic inc, input logic clr, input logic [4:0] rp,
                      input logic [W-1:0] exp, input string nm);
    bus.winc     = inc;
    bus.wovf_clr = clr;
    bus.rptr_q2  = rp;
    @(posedge wclk);
    #1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Asserts reset between clock edges and checks the outputs before any edge.
  task automatic do_reset(input string nm);
    @(negedge wclk);
    #1;
    wrst_n = 1'b0;
    #1;
    exp_q.push_back(ZERO);
    name_q.push_back(nm);
    -> sample_ev;
    step(1'b1, 1'b0, 5'b00110, ZERO, "rst_hold");
    wrst_n = 1'b1;
    step(1'b0, 1'b0, 5'b00000, ZERO, "rst_release");
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    prev_ok      = 1'b0;
    prev_ptr     = '0;
    wrst_n       = 1'b0;
    bus.winc     = 1'b1;
    bus.wovf_clr = 1'b0;
    bus.rptr_q2  = 5'b00110;

    // reset with writes requested
    step(1'b1, 1'b0, 5'b00110, ZERO, "reset_a");
    step(1'b1, 1'b0, 5'b00110, ZERO, "reset_b");
    wrst_n = 1'b1;
    step(1'b0, 1'b0, 5'b00000, ZERO, "reset_release");

    // fill to full
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 5'b00000,
           pk(g(k), 4'(k % 16), k == 16, k >= 14, 5'(k), 1'b0), "fill");
    end

    // overflow set / hold / set-wins / clear
    step(1'b1, 1'b0, 5'b00000, pk(5'b11000, 4'd0, 1'b1, 1'b1, 5'd16, 1'b1), "ovf_set");
    step(1'b0, 1'b0, 5'b00000, pk(5'b11000, 4'd0, 1'b1, 1'b1, 5'd16, 1'b1), "ovf_hold");
    step(1'b1, 1'b1, 5'b00000, pk(5'b11000, 4'd0, 1'b1, 1'b1, 5'd16, 1'b1), "ovf_set_wins");
    step(1'b0, 1'b1, 5'b00000, pk(5'b11000, 4'd0, 1'b1, 1'b1, 5'd16, 1'b0), "ovf_clr");

    // drain four entries, then refill
    step(1'b0, 1'b0, 5'b00110, pk(5'b11000, 4'd0, 1'b0, 1'b0, 5'd12, 1'b0), "drain");
    for (int k = 17; k <= 20; k++) begin
      step(1'b1, 1'b0, 5'b00110,
           pk(g(k), 4'(k % 16), k == 20, (k - 4) >= 14, 5'(k - 4), 1'b0), "refill");
    end

    // wrap with the read pointer trailing two cycles behind
    do_reset("wrap_reset");
    for (int k = 1; k <= 40; k++) begin
      int r;
      r = (k >= 3) ? k - 3 : 0;
      step(1'b1, 1'b0, g(r),
           pk(g(k), 4'(k % 16), 1'b0, 1'b0, 5'(k - r), 1'b0), "wrap");
    end

    // reset in the middle of a fill
    do_reset("pre_fill_reset");
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 1'b0, 5'b00000,
           pk(g(k), 4'(k), 1'b0, 1'b0, 5'(k), 1'b0), "mid_fill");
    end
    do_reset("async_reset");
    step(1'b1, 1'b0, 5'b00000, pk(5'b00001, 4'd1, 1'b0, 1'b0, 5'd1, 1'b0), "first_write");

    bus.winc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge wclk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
